// File: rtl/cci_mpf_shim_vtp_pt_fim_pkg.sv
// Shared types for the VTP page-table-walker / FIM channel.
package cci_mpf_shim_vtp_pt_fim_pkg;

  localparam int unsigned CCI_CLADDR_WIDTH = 42;
  localparam int unsigned CCI_CLDATA_WIDTH = 512;

  localparam int unsigned PT_FIM_MSG_BITS    = 64;
  localparam int unsigned PT_FIM_N_READS_OUT = 4;
  localparam int unsigned PT_FIM_MAX_CREDITS = 16;

  typedef logic [CCI_CLADDR_WIDTH-1:0] t_cci_clAddr;
  typedef logic [CCI_CLDATA_WIDTH-1:0] t_cci_clData;

  // Reorder slot index for the default reorder depth
  typedef logic [$clog2(PT_FIM_N_READS_OUT)-1:0] t_pt_fim_rd_tag;

  // Wide enough to hold any legal write credit count (0..16)
  typedef logic [$clog2(PT_FIM_MAX_CREDITS+1)-1:0] t_pt_fim_wr_credit;

  // Host write line built from a walker message
  function automatic t_cci_clData ptFimMsgToLine(input logic [PT_FIM_MSG_BITS-1:0] msg);
    return {(CCI_CLDATA_WIDTH-PT_FIM_MSG_BITS)'(0), msg};
  endfunction

endpackage

// File: rtl/cci_mpf_svc_vtp_pt_fim_bridge_if.sv
// Walker-side and host-side signals of the PT walker / FIM bridge.
// slave: the bridge's view; master: the walker + host environment.
interface cci_mpf_svc_vtp_pt_fim_bridge_if
  import cci_mpf_shim_vtp_pt_fim_pkg::*;
#(
  parameter int unsigned N_READS_OUT = PT_FIM_N_READS_OUT
);
  localparam int unsigned TAG_W = $clog2(N_READS_OUT);

  logic                       readEn;
  t_cci_clAddr                readAddr;
  logic                       readRdy;
  logic                       readDataEn;
  t_cci_clData                readData;

  logic                       writeEn;
  t_cci_clAddr                writeAddr;
  logic [PT_FIM_MSG_BITS-1:0] writeData;
  logic                       writeRdy;

  logic                       memRdReqValid;
  t_cci_clAddr                memRdReqAddr;
  logic [TAG_W-1:0]           memRdReqTag;
  logic                       memRdReqAlmFull;
  logic                       memRdRspValid;
  logic [TAG_W-1:0]           memRdRspTag;
  t_cci_clData                memRdRspData;

  logic                       memWrReqValid;
  t_cci_clAddr                memWrReqAddr;
  t_cci_clData                memWrReqData;
  logic                       memWrReqAlmFull;
  logic                       memWrRspValid;

  modport slave (
    input  readEn, readAddr, writeEn, writeAddr, writeData,
           memRdReqAlmFull, memRdRspValid, memRdRspTag, memRdRspData,
           memWrReqAlmFull, memWrRspValid,
    output readRdy, readDataEn, readData, writeRdy,
           memRdReqValid, memRdReqAddr, memRdReqTag,
           memWrReqValid, memWrReqAddr, memWrReqData
  );

  modport master (
    output readEn, readAddr, writeEn, writeAddr, writeData,
           memRdReqAlmFull, memRdRspValid, memRdRspTag, memRdRspData,
           memWrReqAlmFull, memWrRspValid,
    input  readRdy, readDataEn, readData, writeRdy,
           memRdReqValid, memRdReqAddr, memRdReqTag,
           memWrReqValid, memWrReqAddr, memWrReqData
  );

endinterface

// File: rtl/cci_mpf_svc_vtp_pt_fim_rob.sv
// Reorder buffer for host read responses: slots are claimed in order,
// filled in any order and delivered strictly in claim order.
module cci_mpf_svc_vtp_pt_fim_rob
  import cci_mpf_shim_vtp_pt_fim_pkg::*;
#(
  parameter int unsigned N_ENTRIES = 4
)
(
  input  logic                         clk,
  input  logic                         reset,

  input  logic                         allocEn,
  output logic                         allocFree,
  output logic [$clog2(N_ENTRIES)-1:0] allocIdx,

  input  logic                         fillEn,
  input  logic [$clog2(N_ENTRIES)-1:0] fillIdx,
  input  t_cci_clData                  fillData,

  output logic                         outEn,
  output t_cci_clData                  outData
);

  localparam int unsigned IDX_W = $clog2(N_ENTRIES);

  logic [N_ENTRIES-1:0] busy;
  logic [N_ENTRIES-1:0] filled;
  t_cci_clData          slotData [N_ENTRIES];
  logic [IDX_W-1:0]     allocPtr;
  logic [IDX_W-1:0]     headPtr;

  logic fillOk;
  logic fillHead;
  logic deliver;

  assign allocFree = !busy[allocPtr];
  assign allocIdx  = allocPtr;

  // Responses to idle slots are stale (e.g. issued before a reset) and dropped
  assign fillOk   = fillEn && busy[fillIdx];
  assign fillHead = fillOk && (fillIdx == headPtr);
  assign deliver  = filled[headPtr] || fillHead;

  // Slot state, pointers and the registered delivery port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy     <= '0;
      filled   <= '0;
      allocPtr <= '0;
      headPtr  <= '0;
      outEn    <= 1'b0;
      outData  <= '0;
    end else begin
      outEn <= deliver;
      if (deliver) begin
        outData <= filled[headPtr] ? slotData[headPtr] : fillData;
      end

      if (allocEn) begin
        busy[allocPtr]   <= 1'b1;
        filled[allocPtr] <= 1'b0;
        allocPtr         <= allocPtr + IDX_W'(1);
      end

      if (fillOk) begin
        filled[fillIdx] <= 1'b1;
      end

      // Delivery clears last so a fill bypassed straight to the head leaves no residue
      if (deliver) begin
        busy[headPtr]   <= 1'b0;
        filled[headPtr] <= 1'b0;
        headPtr         <= headPtr + IDX_W'(1);
      end
    end
  end

  // Data array needs no reset; the filled bits qualify it
  always_ff @(posedge clk) begin
    if (fillOk) begin
      slotData[fillIdx] <= fillData;
    end
  end

endmodule

// File: rtl/cci_mpf_svc_vtp_pt_fim_bridge.sv
// FIM-side bridge for the VTP page-table walker: tagged, reordered host reads
// and credit-limited message writes. Define MPF_VTP_PT_FIM_STATS_EN for counters.
module cci_mpf_svc_vtp_pt_fim_bridge
  import cci_mpf_shim_vtp_pt_fim_pkg::*;
#(
  parameter int unsigned N_READS_OUT  = 4,
  parameter int unsigned N_WRITES_OUT = 4
)
(
  input  logic clk,
  input  logic reset,
  cci_mpf_svc_vtp_pt_fim_bridge_if.slave bus
`ifdef MPF_VTP_PT_FIM_STATS_EN
  ,
  output logic [31:0] statReads,
  output logic [31:0] statWrites,
  output logic [31:0] statRdFullCycles
`endif
);

  localparam int unsigned TAG_W = $clog2(N_READS_OUT);
  localparam t_pt_fim_wr_credit CREDIT_MAX = t_pt_fim_wr_credit'(N_WRITES_OUT);

  logic             allocFree;
  logic [TAG_W-1:0] allocIdx;
  logic             rdAccept;
  logic             wrAccept;
  t_pt_fim_wr_credit wrCredits;

  assign bus.readRdy  = !bus.memRdReqAlmFull && allocFree;
  assign rdAccept     = bus.readEn && bus.readRdy;
  assign bus.writeRdy = !bus.memWrReqAlmFull && (wrCredits != '0);
  assign wrAccept     = bus.writeEn && bus.writeRdy;

  cci_mpf_svc_vtp_pt_fim_rob #(
    .N_ENTRIES (N_READS_OUT)
  ) rob (
    .clk       (clk),
    .reset     (reset),
    .allocEn   (rdAccept),
    .allocFree (allocFree),
    .allocIdx  (allocIdx),
    .fillEn    (bus.memRdRspValid),
    .fillIdx   (bus.memRdRspTag),
    .fillData  (bus.memRdRspData),
    .outEn     (bus.readDataEn),
    .outData   (bus.readData)
  );

  // Host read request register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.memRdReqValid <= 1'b0;
      bus.memRdReqAddr  <= '0;
      bus.memRdReqTag   <= '0;
    end else begin
      bus.memRdReqValid <= rdAccept;
      if (rdAccept) begin
        bus.memRdReqAddr <= bus.readAddr;
        bus.memRdReqTag  <= allocIdx;
      end
    end
  end

  // Host write request register and credit counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.memWrReqValid <= 1'b0;
      bus.memWrReqAddr  <= '0;
      bus.memWrReqData  <= '0;
      wrCredits         <= CREDIT_MAX;
    end else begin
      bus.memWrReqValid <= wrAccept;
      if (wrAccept) begin
        bus.memWrReqAddr <= bus.writeAddr;
        bus.memWrReqData <= ptFimMsgToLine(bus.writeData);
      end

      if (wrAccept && !bus.memWrRspValid) begin
        wrCredits <= wrCredits - t_pt_fim_wr_credit'(1);
      end else if (!wrAccept && bus.memWrRspValid && (wrCredits != CREDIT_MAX)) begin
        wrCredits <= wrCredits + t_pt_fim_wr_credit'(1);
      end
    end
  end

  // An ack with no write outstanding means the host returned a credit it never had
  wrAckOverflow: assert property (@(posedge clk) disable iff (reset)
    !(bus.memWrRspValid && (wrCredits == CREDIT_MAX)));

`ifdef MPF_VTP_PT_FIM_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      statReads        <= '0;
      statWrites       <= '0;
      statRdFullCycles <= '0;
    end else begin
      if (rdAccept)                      statReads        <= statReads + 32'd1;
      if (wrAccept)                      statWrites       <= statWrites + 32'd1;
      if (bus.readEn && !bus.readRdy)    statRdFullCycles <= statRdFullCycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cci_mpf_svc_vtp_pt_fim_bridge.sv
// Directed bench for the PT walker / FIM bridge with hand-computed expectations.
module tb_cci_mpf_svc_vtp_pt_fim_bridge;
  import cci_mpf_shim_vtp_pt_fim_pkg::*;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  cci_mpf_svc_vtp_pt_fim_bridge_if #(.N_READS_OUT(4)) bus ();

`ifdef MPF_VTP_PT_FIM_STATS_EN
  logic [31:0] statReads;
  logic [31:0] statWrites;
  logic [31:0] statRdFullCycles;
`endif

  cci_mpf_svc_vtp_pt_fim_bridge #(
    .N_READS_OUT  (4),
    .N_WRITES_OUT (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef MPF_VTP_PT_FIM_STATS_EN
    ,
    .statReads        (statReads),
    .statWrites       (statWrites),
    .statRdFullCycles (statRdFullCycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic t_cci_clData mkData(input int n);
    return {16{32'hC0DE_0000 | 32'(n)}};
  endfunction

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    bus.readEn = 1'b0;          bus.readAddr = '0;
    bus.writeEn = 1'b0;         bus.writeAddr = '0;       bus.writeData = '0;
    bus.memRdReqAlmFull = 1'b0; bus.memRdRspValid = 1'b0;
    bus.memRdRspTag = '0;       bus.memRdRspData = '0;
    bus.memWrReqAlmFull = 1'b0; bus.memWrRspValid = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_rdReqValid", bus.memRdReqValid, 0);
    check("rst_wrReqValid", bus.memWrReqValid, 0);
    check("rst_readDataEn", bus.readDataEn, 0);
    check("rst_readData", bus.readData, 0);
    reset = 1'b0;
    #1;
    check("rst_readRdy", bus.readRdy, 1);
    check("rst_writeRdy", bus.writeRdy, 1);

    // Single read, response 5 cycles after accept
    bus.readEn = 1'b1; bus.readAddr = 42'h0_1234_5678;
    tick();
    bus.readEn = 1'b0;
    check("t1_reqValid", bus.memRdReqValid, 1);
    check("t1_reqAddr", bus.memRdReqAddr, 42'h0_1234_5678);
    check("t1_reqTag", bus.memRdReqTag, 0);
    tick();
    check("t1_reqValidDrop", bus.memRdReqValid, 0);
    tick(); tick(); tick();
    bus.memRdRspValid = 1'b1; bus.memRdRspTag = 2'd0; bus.memRdRspData = mkData(100);
    #1;
    check("t1_noEarlyData", bus.readDataEn, 0);
    tick();
    bus.memRdRspValid = 1'b0;
    check("t1_dataEn", bus.readDataEn, 1);
    check("t1_data", bus.readData, mkData(100));
    tick();
    check("t1_dataEnPulse", bus.readDataEn, 0);

    // Fresh pointers, then 4 reads answered in tag order 3,1,2,0
    reset = 1'b1; tick(); reset = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      bus.readEn = 1'b1; bus.readAddr = 42'h200 + 42'(i);
      #1;
      check("t2_readRdy", bus.readRdy, 1);
      tick();
      check("t2_reqValid", bus.memRdReqValid, 1);
      check("t2_reqTag", bus.memRdReqTag, 512'(i));
      check("t2_reqAddr", bus.memRdReqAddr, 42'h200 + 42'(i));
    end
    #1;
    check("t2_fullRdy", bus.readRdy, 0);
    tick();
    bus.readEn = 1'b0;
    check("t2_fullNoReq", bus.memRdReqValid, 0);
    bus.memRdRspValid = 1'b1; bus.memRdRspTag = 2'd3; bus.memRdRspData = mkData(3);
    tick();
    check("t2_hold3", bus.readDataEn, 0);
    bus.memRdRspTag = 2'd1; bus.memRdRspData = mkData(1);
    tick();
    check("t2_hold1", bus.readDataEn, 0);
    bus.memRdRspTag = 2'd2; bus.memRdRspData = mkData(2);
    tick();
    check("t2_hold2", bus.readDataEn, 0);
    check("t2_stillFull", bus.readRdy, 0);
    bus.memRdRspTag = 2'd0; bus.memRdRspData = mkData(0);
    tick();
    bus.memRdRspValid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t2_dataEn", bus.readDataEn, 1);
      check("t2_data", bus.readData, mkData(i));
      if (i == 0) check("t2_rdyAfterHead", bus.readRdy, 1);
      tick();
    end
    check("t2_drained", bus.readDataEn, 0);

    // Host read back-pressure with readEn held
    bus.memRdReqAlmFull = 1'b1; bus.readEn = 1'b1; bus.readAddr = 42'h3C0;
    #1;
    check("t3_rdyLow", bus.readRdy, 0);
    tick();
    check("t3_noReq0", bus.memRdReqValid, 0);
    tick();
    check("t3_noReq1", bus.memRdReqValid, 0);
    bus.memRdReqAlmFull = 1'b0;
    #1;
    check("t3_rdyBack", bus.readRdy, 1);
    tick();
    bus.readEn = 1'b0;
    check("t3_reqValid", bus.memRdReqValid, 1);
    check("t3_reqAddr", bus.memRdReqAddr, 42'h3C0);
    check("t3_reqTag", bus.memRdReqTag, 0);
    bus.memRdRspValid = 1'b1; bus.memRdRspTag = 2'd0; bus.memRdRspData = mkData(55);
    tick();
    bus.memRdRspValid = 1'b0;
    check("t3_data", bus.readData, mkData(55));

    // Five writes against four credits
    bus.writeEn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.writeAddr = 42'h500 + 42'(i); bus.writeData = 64'hFEED_0000_0000_0000 | 64'(i);
      #1;
      check("t4_writeRdy", bus.writeRdy, 1);
      tick();
      check("t4_wrValid", bus.memWrReqValid, 1);
      check("t4_wrAddr", bus.memWrReqAddr, 42'h500 + 42'(i));
      check("t4_wrData", bus.memWrReqData, 512'(64'hFEED_0000_0000_0000 | 64'(i)));
    end
    bus.writeAddr = 42'h5AA; bus.writeData = 64'h0123_4567_89AB_CDEF;
    #1;
    check("t4_noCredit", bus.writeRdy, 0);
    bus.memWrRspValid = 1'b1;
    tick();
    bus.memWrRspValid = 1'b0;
    check("t4_stalled", bus.memWrReqValid, 0);
    #1;
    check("t4_creditBack", bus.writeRdy, 1);
    tick();
    bus.writeEn = 1'b0;
    check("t4_fifthValid", bus.memWrReqValid, 1);
    check("t4_fifthAddr", bus.memWrReqAddr, 42'h5AA);
    check("t4_fifthUpper", bus.memWrReqData[511:64], 0);
    check("t4_fifthLower", bus.memWrReqData[63:0], 64'h0123_4567_89AB_CDEF);

    // Reset with two reads outstanding; their late responses must vanish
    reset = 1'b1; tick(); reset = 1'b0; #1;
    bus.readEn = 1'b1; bus.readAddr = 42'h700;
    tick();
    bus.readAddr = 42'h701;
    tick();
    bus.readEn = 1'b0;
    check("t5_secondTag", bus.memRdReqTag, 1);
    reset = 1'b1;
    #1;
    check("t5_asyncClear", bus.memRdReqValid, 0);
    tick();
    reset = 1'b0;
    bus.memRdRspValid = 1'b1; bus.memRdRspTag = 2'd0; bus.memRdRspData = mkData(70);
    tick();
    check("t5_drop0", bus.readDataEn, 0);
    bus.memRdRspTag = 2'd1; bus.memRdRspData = mkData(71);
    tick();
    bus.memRdRspValid = 1'b0;
    check("t5_drop1", bus.readDataEn, 0);
    tick();
    check("t5_drop2", bus.readDataEn, 0);
    bus.readEn = 1'b1; bus.readAddr = 42'h710;
    tick();
    bus.readEn = 1'b0;
    check("t5_newValid", bus.memRdReqValid, 1);
    check("t5_newTag", bus.memRdReqTag, 0);

`ifdef MPF_VTP_PT_FIM_STATS_EN
    // Counters: 3 reads, 7 blocked read cycles, 2 writes
    reset = 1'b1; tick(); reset = 1'b0; #1;
    check("st_rst", statReads, 0);
    bus.readEn = 1'b1;
    tick(); tick(); tick();
    bus.memRdReqAlmFull = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    bus.memRdReqAlmFull = 1'b0; bus.readEn = 1'b0;
    bus.writeEn = 1'b1;
    tick(); tick();
    bus.writeEn = 1'b0;
    tick();
    check("st_reads", statReads, 3);
    check("st_writes", statWrites, 2);
    check("st_rdFull", statRdFullCycles, 7);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
